// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner select between the CPU and DMA requesters.
// Build option MEM_ARB_RR_EN: round-robin on ties instead of fixed CPU priority.
module arb_priority_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic owner,
    output logic grant_valid,
    output logic grant
);

    assign grant_valid = cpu_req | dma_req;

`ifdef MEM_ARB_RR_EN
    // A tie goes to whichever port did not win last time.
    always_comb begin
        if (cpu_req && dma_req) begin
            grant = ~owner;
        end else if (cpu_req) begin
            grant = OWN_CPU;
        end else begin
            grant = OWN_DMA;
        end
    end
`else
    logic unused_owner;
    assign unused_owner = owner;
    assign grant        = cpu_req ? OWN_CPU : OWN_DMA;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified CPU memory port between the CPU and a DMA engine.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking (see arb_priority_pick).
//
// state      | meaning
// ARB_IDLE   | sample requests, latch the winner's transaction
// ARB_ACCESS | drive memory strobes for MEM_LATENCY cycles
// ARB_RESP   | one-cycle ready pulse to the winner
module mem_port_arbiter #(
    parameter int WORD_SIZE   = mem_arb_pkg::WORD_SIZE,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic [WORD_SIZE-1:0] dma_rdata,
    output logic                 dma_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 owner,
    output logic                 busy
);
    import mem_arb_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    arb_state_e           state;
    arb_state_e           state_next;
    logic [3:0]           cnt;
    logic                 we_lat;
    logic [WORD_SIZE-1:0] addr_lat;
    logic [WORD_SIZE-1:0] wdata_lat;
    logic                 grant_valid;
    logic                 grant;

    arb_priority_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .owner       (owner),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ready  = 1'b0;
        dma_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                busy      = 1'b1;
                mem_read  = ~we_lat;
                mem_write = we_lat;
                mem_addr  = addr_lat;
                mem_wdata = wdata_lat;
                if (cnt == 4'd0) begin
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                busy       = 1'b1;
                cpu_ready  = (owner == OWN_CPU);
                dma_ready  = (owner == OWN_DMA);
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            cnt       <= 4'd0;
            we_lat    <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            owner     <= OWN_DMA;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant;
                        we_lat    <= (grant == OWN_CPU) ? cpu_we    : dma_we;
                        addr_lat  <= (grant == OWN_CPU) ? cpu_addr  : dma_addr;
                        wdata_lat <= (grant == OWN_CPU) ? cpu_wdata : dma_wdata;
                        cnt       <= CNT_LOAD;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!we_lat) begin
                        // Last strobe cycle: memory data is valid now.
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            dma_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         cpu_req, cpu_we, cpu_ready;
    logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic         dma_req, dma_we, dma_ready;
    logic [W-1:0] dma_addr, dma_wdata, dma_rdata;
    logic         mem_read, mem_write, owner, busy;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    logic         l1_reset, l1_cpu_req, l1_cpu_ready, l1_dma_ready;
    logic [W-1:0] l1_cpu_addr, l1_cpu_rdata, l1_dma_rdata;
    logic         l1_mem_read, l1_mem_write, l1_owner, l1_busy;
    logic [W-1:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] mem_func(input logic [W-1:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign mem_rdata    = mem_func(mem_addr);
    assign l1_mem_rdata = mem_func(l1_mem_addr);

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(l1_reset),
        .cpu_req(l1_cpu_req), .cpu_we(1'b0), .cpu_addr(l1_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_rdata(l1_dma_rdata), .dma_ready(l1_dma_ready),
        .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
        .owner(l1_owner), .busy(l1_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drives one transaction on a port and records what the memory side and ready outputs did.
    task automatic run_txn(input bit port, input bit we, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, output int n_strobe, output int rdy_at,
                           output int n_rdy, output int n_other, output logic [W-1:0] seen_addr,
                           output logic [W-1:0] seen_wdata, output bit seen_we);
        n_strobe = 0; rdy_at = -1; n_rdy = 0; n_other = 0;
        seen_addr = '0; seen_wdata = '0; seen_we = 1'b0;
        if (port == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (mem_read || mem_write) begin
                n_strobe++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
                seen_we    = mem_write;
            end
            if (port ? dma_ready : cpu_ready) begin
                n_rdy++;
                if (rdy_at < 0) rdy_at = n;
                if (port) dma_req = 1'b0; else cpu_req = 1'b0;
            end
            if (port ? cpu_ready : dma_ready) n_other++;
            if (rdy_at >= 0 && n >= rdy_at + 3) break;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b%b exp 00", cpu_ready, dma_ready); end
        checks++; if (cpu_rdata !== '0 || dma_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", cpu_rdata, dma_rdata); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_cpu_read();
        int ns, ra, nr, no;
        logic [W-1:0] sa, sw;
        bit swe;
        do_reset();
        run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, ns, ra, nr, no, sa, sw, swe);
        checks++; if (ns != 2)  begin errors++; $display("FAIL cpu_read_strobes got %0d exp 2", ns); end
        checks++; if (ra != 3)  begin errors++; $display("FAIL cpu_read_latency got %0d exp 3", ra); end
        checks++; if (nr != 1)  begin errors++; $display("FAIL cpu_read_pulses got %0d exp 1", nr); end
        checks++; if (no != 0)  begin errors++; $display("FAIL cpu_read_dma_ready got %0d exp 0", no); end
        checks++; if (sa !== 16'h0010 || swe !== 1'b0) begin
            errors++; $display("FAIL cpu_read_mem_side got addr %h we %b exp 0010 0", sa, swe); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_rdata got %h exp BEEF", cpu_rdata); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL cpu_read_owner got %b exp 0", owner); end
    endtask

    task automatic test_dma_write();
        int ns, ra, nr, no;
        logic [W-1:0] sa, sw;
        bit swe;
        run_txn(1'b1, 1'b0, 16'h0300, 16'h0000, ns, ra, nr, no, sa, sw, swe);
        checks++; if (dma_rdata !== mem_func(16'h0300)) begin
            errors++; $display("FAIL dma_read_rdata got %h exp %h", dma_rdata, mem_func(16'h0300)); end
        run_txn(1'b1, 1'b1, 16'h0200, 16'h1234, ns, ra, nr, no, sa, sw, swe);
        checks++; if (ns != 2 || swe !== 1'b1) begin
            errors++; $display("FAIL dma_write_strobes got %0d we %b exp 2 1", ns, swe); end
        checks++; if (sa !== 16'h0200 || sw !== 16'h1234) begin
            errors++; $display("FAIL dma_write_mem_side got %h/%h exp 0200/1234", sa, sw); end
        checks++; if (ra != 3 || nr != 1 || no != 0) begin
            errors++; $display("FAIL dma_write_ready got at %0d n %0d other %0d exp 3 1 0", ra, nr, no); end
        checks++; if (dma_rdata !== mem_func(16'h0300)) begin
            errors++; $display("FAIL dma_write_rdata_kept got %h exp %h", dma_rdata, mem_func(16'h0300)); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL dma_write_cpu_rdata got %h exp BEEF", cpu_rdata); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL dma_write_owner got %b exp 1", owner); end
    endtask

    task automatic test_tie();
        int order[$];
        int times[$];
        bit exp_win;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0040;
        for (int n = 1; n <= 40 && order.size() < 4; n++) begin
            tick();
            if (cpu_ready) begin order.push_back(0); times.push_back(n); end
            if (dma_ready) begin order.push_back(1); times.push_back(n); end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        checks++; if (order.size() != 4) begin errors++; $display("FAIL tie_count got %0d exp 4", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
`ifdef MEM_ARB_RR_EN
            exp_win = (i % 2 == 1);
`else
            exp_win = 1'b0;
`endif
            checks++; if (order[i] != int'(exp_win)) begin
                errors++; $display("FAIL tie_order[%0d] got %0d exp %0d", i, order[i], exp_win); end
            if (i > 0) begin
                checks++; if (times[i] - times[i-1] != LAT + 2) begin
                    errors++; $display("FAIL tie_spacing[%0d] got %0d exp %0d", i, times[i] - times[i-1], LAT + 2); end
            end
        end
        checks++; if (cpu_rdata !== mem_func(16'h0030)) begin
            errors++; $display("FAIL tie_cpu_rdata got %h exp %h", cpu_rdata, mem_func(16'h0030)); end
`ifdef MEM_ARB_RR_EN
        checks++; if (dma_rdata !== mem_func(16'h0040)) begin
            errors++; $display("FAIL tie_dma_rdata got %h exp %h", dma_rdata, mem_func(16'h0040)); end
`else
        checks++; if (dma_rdata !== '0) begin errors++; $display("FAIL tie_dma_rdata got %h exp 0", dma_rdata); end
`endif
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        int ns, ra, nr, no, stray;
        logic [W-1:0] sa, sw;
        bit swe;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
        tick();
        checks++; if (mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_access_entry got read %b busy %b exp 1 1", mem_read, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++; $display("FAIL mid_access_abort got read %b busy %b ready %b exp 0 0 0", mem_read, busy, cpu_ready); end
        stray = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (cpu_ready || dma_ready || busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_access_quiet got %0d active cycles exp 0", stray); end
        run_txn(1'b0, 1'b0, 16'h0050, 16'h0000, ns, ra, nr, no, sa, sw, swe);
        checks++; if (ra != 3 || nr != 1) begin
            errors++; $display("FAIL mid_access_retry got at %0d n %0d exp 3 1", ra, nr); end
        checks++; if (cpu_rdata !== mem_func(16'h0050)) begin
            errors++; $display("FAIL mid_access_rdata got %h exp %h", cpu_rdata, mem_func(16'h0050)); end
    endtask

    task automatic test_lat1_back_to_back();
        int strobes = 0, idx = 0, bad_side = 0;
        int rtimes[$];
        l1_reset = 1'b1;
        tick(); tick();
        l1_reset = 1'b0;
        l1_cpu_req  = 1'b1;
        l1_cpu_addr = 16'd0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (l1_dma_ready || l1_mem_write) bad_side++;
            if (l1_mem_read) begin
                strobes++;
                checks++; if (l1_mem_addr !== W'(idx)) begin
                    errors++; $display("FAIL lat1_addr got %h exp %h", l1_mem_addr, W'(idx)); end
            end
            if (l1_cpu_ready) begin
                rtimes.push_back(n);
                checks++; if (l1_cpu_rdata !== mem_func(W'(idx))) begin
                    errors++; $display("FAIL lat1_rdata[%0d] got %h exp %h", idx, l1_cpu_rdata, mem_func(W'(idx))); end
                idx++;
                if (idx == 3) l1_cpu_req = 1'b0;
                else l1_cpu_addr = W'(idx);
            end
        end
        l1_cpu_req = 1'b0;
        checks++; if (strobes != 3) begin errors++; $display("FAIL lat1_strobes got %0d exp 3", strobes); end
        checks++; if (rtimes.size() != 3) begin errors++; $display("FAIL lat1_ready_count got %0d exp 3", rtimes.size()); end
        for (int i = 0; i < rtimes.size() && i < 3; i++) begin
            checks++; if (rtimes[i] != 2 + 3 * i) begin
                errors++; $display("FAIL lat1_ready_time[%0d] got %0d exp %0d", i, rtimes[i], 2 + 3 * i); end
        end
        checks++; if (bad_side != 0) begin errors++; $display("FAIL lat1_side_outputs got %0d exp 0", bad_side); end
        checks++; if (l1_owner !== 1'b0 || l1_busy !== 1'b0 || l1_dma_rdata !== '0 || l1_mem_wdata !== '0) begin
            errors++; $display("FAIL lat1_final got owner %b busy %b drd %h wd %h exp 0 0 0 0",
                               l1_owner, l1_busy, l1_dma_rdata, l1_mem_wdata); end
    endtask

    // Reference model: each granted transaction is a timeline of absolute cycle numbers
    // (strobes m_start..m_end, ready at m_rdy); a new grant is possible only after m_rdy.
    task automatic test_random();
        int m_start = -1, m_end = -1, m_rdy = -1;
        bit m_win = 1'b0, m_we = 1'b0, m_owner = 1'b1, strobe, win;
        logic [W-1:0] m_addr = '0, m_wdata = '0, m_crd = '0, m_drd = '0, e_addr, e_wdata;
        bit pend[2];
        bit t_we[2];
        logic [W-1:0] t_addr[2];
        logic [W-1:0] t_wdata[2];
        pend[0] = 1'b0; pend[1] = 1'b0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            tick();
            if (n == m_rdy && !m_we) begin
                if (m_win) m_drd = mem_func(m_addr); else m_crd = mem_func(m_addr);
            end
            strobe  = (n >= m_start && n <= m_end);
            e_addr  = strobe ? m_addr : '0;
            e_wdata = strobe ? m_wdata : '0;
            checks++; if (mem_read !== (strobe && !m_we)) begin
                errors++; $display("FAIL rnd_mem_read cyc %0d got %b exp %b", n, mem_read, strobe && !m_we); end
            checks++; if (mem_write !== (strobe && m_we)) begin
                errors++; $display("FAIL rnd_mem_write cyc %0d got %b exp %b", n, mem_write, strobe && m_we); end
            checks++; if (mem_addr !== e_addr) begin
                errors++; $display("FAIL rnd_mem_addr cyc %0d got %h exp %h", n, mem_addr, e_addr); end
            checks++; if (mem_wdata !== e_wdata) begin
                errors++; $display("FAIL rnd_mem_wdata cyc %0d got %h exp %h", n, mem_wdata, e_wdata); end
            checks++; if (cpu_ready !== (n == m_rdy && !m_win)) begin
                errors++; $display("FAIL rnd_cpu_ready cyc %0d got %b exp %b", n, cpu_ready, n == m_rdy && !m_win); end
            checks++; if (dma_ready !== (n == m_rdy && m_win)) begin
                errors++; $display("FAIL rnd_dma_ready cyc %0d got %b exp %b", n, dma_ready, n == m_rdy && m_win); end
            checks++; if (busy !== (n >= m_start && n <= m_rdy)) begin
                errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", n, busy, n >= m_start && n <= m_rdy); end
            checks++; if (owner !== m_owner) begin
                errors++; $display("FAIL rnd_owner cyc %0d got %b exp %b", n, owner, m_owner); end
            checks++; if (cpu_rdata !== m_crd) begin
                errors++; $display("FAIL rnd_cpu_rdata cyc %0d got %h exp %h", n, cpu_rdata, m_crd); end
            checks++; if (dma_rdata !== m_drd) begin
                errors++; $display("FAIL rnd_dma_rdata cyc %0d got %h exp %h", n, dma_rdata, m_drd); end

            if (n == m_rdy) pend[m_win] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]    = 1'b1;
                    t_we[p]    = 1'($urandom_range(0, 1));
                    t_addr[p]  = W'($urandom);
                    t_wdata[p] = W'($urandom);
                end
            end
            cpu_req = pend[0]; cpu_we = t_we[0]; cpu_addr = t_addr[0]; cpu_wdata = t_wdata[0];
            dma_req = pend[1]; dma_we = t_we[1]; dma_addr = t_addr[1]; dma_wdata = t_wdata[1];

            if (n > m_rdy && (pend[0] || pend[1])) begin
`ifdef MEM_ARB_RR_EN
                win = (pend[0] && pend[1]) ? ~m_owner : pend[1];
`else
                win = !pend[0];
`endif
                m_win   = win;
                m_owner = win;
                m_we    = t_we[win];
                m_addr  = t_addr[win];
                m_wdata = t_wdata[win];
                m_start = n + 1;
                m_end   = n + LAT;
                m_rdy   = n + LAT + 1;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        l1_reset = 1'b1; l1_cpu_req = 1'b0; l1_cpu_addr = '0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_tie();
        test_reset_mid_access();
        test_lat1_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
